// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and width helpers for the instruction fetch front-end
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    HALT_PEND = 2'd1,
    DONE      = 2'd2
  } fetch_state_e;

  localparam int FETCH_D_DEFAULT     = 12;
  localparam int FETCH_IW_DEFAULT    = 9;
  localparam int FETCH_DEPTH_DEFAULT = 4;

  // Counter width able to represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - circular prefetch buffer with flush priority over push/pop
module prefetch_fifo
  import fetch_pkg::*;
#(
  parameter int W     = 21,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        push,
  input  logic                        pop,
  input  logic [W-1:0]                wdata,
  output logic [W-1:0]                rdata,
  output logic [occ_width(DEPTH)-1:0] count
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = occ_width(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/prefetch_fetch_unit.sv
// rtl/prefetch_fetch_unit.sv - PC, prefetch FIFO and halt FSM feeding decode via valid/ready
module prefetch_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              D          = 12,
  parameter int              IW         = 9,
  parameter int              DEPTH      = 4,
  parameter logic [IW-1:0]   HALT_INSTR = 9'h1FF
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [D-1:0]                rom_addr,
  input  logic [IW-1:0]               rom_data,
  input  logic                        jump_en,
  input  logic [D-1:0]                jump_target,
  input  logic                        instr_ready,
  output logic                        instr_valid,
  output logic [IW-1:0]               instr,
  output logic [D-1:0]                instr_pc,
  output logic [occ_width(DEPTH)-1:0] occupancy,
  output logic                        done
);

  localparam int CW = occ_width(DEPTH);

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [D-1:0]  pc;
  } fetch_entry_t;

  fetch_state_e state, state_next;
  logic [D-1:0] fetch_pc;
  fetch_entry_t head, wentry;
  logic [CW-1:0] count;
  logic push, pop, flush;

  assign wentry    = '{instr: rom_data, pc: fetch_pc};
  assign rom_addr  = fetch_pc;
  assign occupancy = count;

  prefetch_fifo #(
    .W    ($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .push (push),
    .pop  (pop),
    .wdata(wentry),
    .rdata(head),
    .count(count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      fetch_pc <= '0;
    end else begin
      state <= state_next;
      if (flush)     fetch_pc <= jump_target;
      else if (push) fetch_pc <= fetch_pc + D'(1);
    end
  end

  // A jump out of HALT_PEND discards the speculatively fetched halt.
  always_comb begin
    state_next = state;
    case (state)
      FETCH:     if (push && rom_data == HALT_INSTR) state_next = HALT_PEND;
      HALT_PEND: begin
        if (jump_en)                                state_next = FETCH;
        else if (pop && head.instr == HALT_INSTR)   state_next = DONE;
      end
      DONE:      state_next = DONE;
      default:   state_next = FETCH;
    endcase
  end

  always_comb begin
    instr_valid = (state != DONE) && (count != '0);
    instr       = instr_valid ? head.instr : '0;
    instr_pc    = instr_valid ? head.pc : '0;
    done        = (state == DONE);
    pop         = instr_valid && instr_ready;
    flush       = jump_en && (state != DONE);
    push        = (state == FETCH) && !jump_en && ((count < CW'(DEPTH)) || pop);
  end

endmodule
